cop_dispatch: RTL and testbench
===============================

# cop_dispatch

Parametrised coprocessor dispatch unit between the processor core and up to four coprocessors (CP0–CP3), replacing point-to-point core/coprocessor wiring. It accepts coprocessor instructions with an operand over a valid/ready handshake and decodes the COPz field. It forwards each instruction to the selected channel through a registered issue stage and returns results to the core strictly in issue order, using a tag FIFO of outstanding operations. Illegal or unpopulated-coprocessor instructions are answered in order with an error response instead of being dispatched.

## Interface
- NUM_COP, 2, number of coprocessor channels, 1..4
- DATA_W, 32, operand/result width
- DEPTH, 4, maximum outstanding operations; power of two, ≥2
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  unit accepts request this cycle
- req_inst  in  32  instruction word
- req_data  in  DATA_W  operand
- rsp_valid  out  1  result to core valid
- rsp_ready  in  1  core accepts result
- rsp_data  out  DATA_W  result; 0 on error
- rsp_err  out  1  result is an illegal-instruction error
- cop_valid  out  NUM_COP  one-hot dispatch valid
- cop_ready  in  NUM_COP  per-channel accept
- cop_inst  out  32  shared dispatched instruction
- cop_data  out  DATA_W  shared dispatched operand
- cop_rsp_valid  in  NUM_COP  per-channel result valid
- cop_rsp_data  in  NUM_COP*DATA_W  per-channel result; channel c at [c*DATA_W +: DATA_W]
- cop_rsp_flags  in  NUM_COP*8  per-channel status flags accompanying result
- cop_rsp_ready  out  NUM_COP  per-channel result accept
- flags_clr  in  1  clear sticky flags
- sticky_flags  out  NUM_COP*8  accumulated flags per channel
- outstanding  out  $clog2(DEPTH+1)  tag FIFO occupancy

## Operation
- Decode:
  - Legal only if req_inst[31:28]==4'b0100; channel z = req_inst[27:26].
  - Legal channel requires z < NUM_COP; anything else is illegal.
- Accept when req_valid && req_ready.
- req_ready = (!issue_vld || issue_fire) && (outstanding < DEPTH).
  - issue_fire is the cop_valid/cop_ready handshake on the issue register's channel.
  - A same-cycle response pop does not free a FIFO slot for acceptance.
- On accept, push tag {err, chan} into the tag FIFO.
- Legal accept additionally loads the issue register (inst, data, chan, issue_vld=1).
- Illegal accept does not touch the issue register.
- Issue register drives cop_inst, cop_data and cop_valid[chan]=1; it holds until cop_ready[chan]=1.
- Response selection, FIFO head only:
  - Head err: rsp_valid=1, rsp_err=1, rsp_data=0, all cop_rsp_ready=0.
  - Head legal channel h: rsp_valid=cop_rsp_valid[h], rsp_data=channel h data, cop_rsp_ready[h]=rsp_ready, other cop_rsp_ready=0.
- Pop on rsp_valid && rsp_ready.
- Results from non-head channels are back-pressured; ordering is preserved regardless of coprocessor latency.
- outstanding: +1 on push, −1 on pop; simultaneous push and pop leaves it unchanged.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - cop_valid=0, rsp_valid=0, rsp_err=0, rsp_data=0.
  - cop_rsp_ready=0, sticky_flags=0, outstanding=0.
  - req_ready=1, cop_inst=0, cop_data=0.
- Dispatch latency: request accepted at edge N, cop_valid visible after edge N until its handshake.
- Back-to-back issue at one per cycle when cop_ready is held high.
- Response path is combinational: cop_rsp → rsp in the same cycle, no added latency.
- Error response valid the cycle after acceptance if its tag is at the head.
- FIFO full: req_ready=0 until a pop has registered.
- Reset mid-operation clears the issue register, tag FIFO and sticky flags immediately.
  - Coprocessors must share rst; results in flight at reset are discarded.

## Configuration
- COP_DISPATCH_STICKY_FLAGS_EN defined:
  - On each legal pop from channel c, sticky_flags[c*8 +: 8] |= that channel's cop_rsp_flags.
  - flags_clr zeroes all bits.
  - flags_clr coincident with a pop: register takes exactly the popped flags (set wins).
- Not defined: sticky_flags tied to 0; flags_clr and cop_rsp_flags ignored.

## Test plan
- Single op: CP1 inst 0x44800000, data 0x12345678; cop_ready[1]=1 → cop_valid=2'b10 next cycle; cop returns 0xCAFEF00D → rsp_data 0xCAFEF00D, rsp_err=0, outstanding 1→0.
- Out-of-order completion: issue CP0 then CP1; CP1 responds first → cop_rsp_ready[1]=0 until CP0 result popped; core sees CP0 result, then CP1 result.
- Illegal: req_inst 0x00000020 between two CP0 ops → no cop_valid; second response is rsp_err=1, rsp_data=0, in position.
- Unpopulated: NUM_COP=2, inst 0x4C000000 (COP3) → error response, no dispatch.
- Full/back-pressure: DEPTH=4, cop_rsp_valid=0, 4 requests accepted → req_ready=0, outstanding=4; one pop → req_ready=1 next cycle.
- Sticky flags (macro on): CP0 flags 0x01 then 0x04 → sticky 0x05; flags_clr with a pop carrying 0x02 → 0x02; async rst low mid-stream → all outputs at reset values.

Source files
------------

// File: rtl/cop_dispatch_if.sv
// cop_dispatch_if: bundle of the core request/response channel, the
// coprocessor dispatch/result channels and the sticky-flag/occupancy status
// of cop_dispatch. The dispatch unit uses the slave modport; the core and
// coprocessor side (or a testbench standing in for it) uses master.
interface cop_dispatch_if #(
  parameter int NUM_COP = 2,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Core request channel
  logic                      req_valid;
  logic                      req_ready;
  logic [31:0]               req_inst;
  logic [DATA_W-1:0]         req_data;
  // Core response channel
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  // Shared dispatch bus to the coprocessors
  logic [NUM_COP-1:0]        cop_valid;
  logic [NUM_COP-1:0]        cop_ready;
  logic [31:0]               cop_inst;
  logic [DATA_W-1:0]         cop_data;
  // Per-channel result return
  logic [NUM_COP-1:0]        cop_rsp_valid;
  logic [NUM_COP*DATA_W-1:0] cop_rsp_data;
  logic [NUM_COP*8-1:0]      cop_rsp_flags;
  logic [NUM_COP-1:0]        cop_rsp_ready;
  // Status
  logic                      flags_clr;
  logic [NUM_COP*8-1:0]      sticky_flags;
  logic [CNT_W-1:0]          outstanding;

  modport slave (
    input  req_valid, req_inst, req_data, rsp_ready,
    input  cop_ready, cop_rsp_valid, cop_rsp_data, cop_rsp_flags, flags_clr,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output cop_valid, cop_inst, cop_data, cop_rsp_ready,
    output sticky_flags, outstanding
  );

  modport master (
    output req_valid, req_inst, req_data, rsp_ready,
    output cop_ready, cop_rsp_valid, cop_rsp_data, cop_rsp_flags, flags_clr,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  cop_valid, cop_inst, cop_data, cop_rsp_ready,
    input  sticky_flags, outstanding
  );
endinterface

// File: rtl/cop_dispatch.sv
// cop_dispatch: coprocessor dispatch unit. Decodes the COPz field of core
// requests, issues legal ones to one of NUM_COP channels through a single
// registered issue stage, and returns results to the core strictly in issue
// order using a tag FIFO of outstanding operations. Illegal or unpopulated
// coprocessor instructions get an in-order error response instead.
// Optional feature: define COP_DISPATCH_STICKY_FLAGS_EN to accumulate the
// per-channel result flags into sticky_flags (cleared by flags_clr).
module cop_dispatch #(
  parameter int NUM_COP = 2,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4
) (
  input  logic           clk,
  input  logic           rst,
  cop_dispatch_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Decode
  logic [1:0]          w_req_chan;
  logic                w_legal;
  logic                w_push;
  logic                w_pop;
  logic                w_pop_legal;
  logic                w_req_ready;

  // Issue stage
  logic                r_iss_vld_p1;
  logic [1:0]          r_iss_chan_p1;
  logic [31:0]         r_iss_inst_p1;
  logic [DATA_W-1:0]   r_iss_data_p1;
  logic [NUM_COP-1:0]  w_cop_valid;
  logic                w_iss_fire;

  // Tag FIFO: entry = {err, chan}
  logic [2:0]          r_tag_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [2:0]          w_head;
  logic                w_empty;
  logic                w_head_err;
  logic [1:0]          w_head_chan;

  // Response
  logic                w_rsp_valid;
  logic [DATA_W-1:0]   w_rsp_data;
  logic [NUM_COP-1:0]  w_cop_rsp_ready;

  assign w_req_chan = bus.req_inst[27:26];
  assign w_legal    = (bus.req_inst[31:28] == 4'b0100) &&
                      (int'(w_req_chan) < NUM_COP);

  // One-hot channel valid from the issue register
  always_comb begin
    w_cop_valid = '0;
    for (int c = 0; c < NUM_COP; c++) begin
      w_cop_valid[c] = r_iss_vld_p1 && (r_iss_chan_p1 == 2'(c));
    end
  end

  assign w_iss_fire = |(w_cop_valid & bus.cop_ready);

  // A pop in the same cycle deliberately does not free a slot for acceptance
  assign w_req_ready = (!r_iss_vld_p1 || w_iss_fire) && (r_count < CNT_W'(DEPTH));
  assign w_push      = bus.req_valid && w_req_ready;

  // Issue register: loaded by legal accepts, held until the channel handshakes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_iss_vld_p1  <= 1'b0;
      r_iss_chan_p1 <= '0;
      r_iss_inst_p1 <= '0;
      r_iss_data_p1 <= '0;
    end else if (w_push && w_legal) begin
      r_iss_vld_p1  <= 1'b1;
      r_iss_chan_p1 <= w_req_chan;
      r_iss_inst_p1 <= bus.req_inst;
      r_iss_data_p1 <= bus.req_data;
    end else if (w_iss_fire) begin
      r_iss_vld_p1  <= 1'b0;
    end
  end

  // Tag storage; validity is tracked by the pointers and count, so no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= {~w_legal, w_req_chan};
    end
  end

  assign w_head      = r_tag_mem[r_rd_ptr];
  assign w_empty     = (r_count == '0);
  assign w_head_err  = !w_empty && w_head[2];
  assign w_head_chan = w_head[1:0];

  // In-order response steering: only the FIFO head's channel may return
  always_comb begin
    w_rsp_valid     = 1'b0;
    w_rsp_data      = '0;
    w_cop_rsp_ready = '0;
    if (w_head_err) begin
      w_rsp_valid = 1'b1;
    end else if (!w_empty) begin
      for (int c = 0; c < NUM_COP; c++) begin
        if (w_head_chan == 2'(c)) begin
          w_rsp_valid        = bus.cop_rsp_valid[c];
          w_rsp_data         = bus.cop_rsp_data[c*DATA_W +: DATA_W];
          w_cop_rsp_ready[c] = bus.rsp_ready;
        end
      end
    end
  end

  assign w_pop       = w_rsp_valid && bus.rsp_ready;
  assign w_pop_legal = w_pop && !w_head_err;

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef COP_DISPATCH_STICKY_FLAGS_EN
  logic [NUM_COP*8-1:0] r_sticky;
  logic [NUM_COP*8-1:0] w_sticky_nxt;

  // Clear first, then OR in the popped flags so a coincident set wins
  always_comb begin
    w_sticky_nxt = bus.flags_clr ? '0 : r_sticky;
    if (w_pop_legal) begin
      for (int c = 0; c < NUM_COP; c++) begin
        if (w_head_chan == 2'(c)) begin
          w_sticky_nxt[c*8 +: 8] = w_sticky_nxt[c*8 +: 8] | bus.cop_rsp_flags[c*8 +: 8];
        end
      end
    end
  end

  // Sticky flag register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sticky <= '0;
    else      r_sticky <= w_sticky_nxt;
  end

  assign bus.sticky_flags = r_sticky;
`else
  assign bus.sticky_flags = '0;
`endif

  assign bus.req_ready     = w_req_ready;
  assign bus.rsp_valid     = w_rsp_valid;
  assign bus.rsp_data      = w_rsp_data;
  assign bus.rsp_err       = w_head_err;
  assign bus.cop_valid     = w_cop_valid;
  assign bus.cop_inst      = r_iss_inst_p1;
  assign bus.cop_data      = r_iss_data_p1;
  assign bus.cop_rsp_ready = w_cop_rsp_ready;
  assign bus.outstanding   = r_count;
endmodule

// File: tb/tb_cop_dispatch.sv
// tb_cop_dispatch: directed bench for cop_dispatch (NUM_COP=2, DEPTH=4,
// DATA_W=32). Inputs change 1 time unit after the rising edge; outputs are
// sampled a further unit later.
module tb_cop_dispatch;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cop_dispatch_if #(.NUM_COP(2), .DATA_W(32), .DEPTH(4)) bus ();

  cop_dispatch #(.NUM_COP(2), .DATA_W(32), .DEPTH(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] data);
    bus.req_valid = 1'b1;
    bus.req_inst  = inst;
    bus.req_data  = data;
    tick();
    bus.req_valid = 1'b0;
  endtask

  logic [15:0] exp_sticky;

  initial begin
    bus.req_valid     = 1'b0;
    bus.req_inst      = '0;
    bus.req_data      = '0;
    bus.rsp_ready     = 1'b0;
    bus.cop_ready     = '0;
    bus.cop_rsp_valid = '0;
    bus.cop_rsp_data  = '0;
    bus.cop_rsp_flags = '0;
    bus.flags_clr     = 1'b0;

    // Reset values
    tick(); tick();
    #1;
    chk("rst_cop_valid", bus.cop_valid, 2'b00);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, 32'h0);
    chk("rst_cop_rsp_ready", bus.cop_rsp_ready, 2'b00);
    chk("rst_sticky", bus.sticky_flags, 16'h0);
    chk("rst_outstanding", bus.outstanding, 3'd0);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_cop_inst", bus.cop_inst, 32'h0);
    chk("rst_cop_data", bus.cop_data, 32'h0);
    rst = 1'b1;
    tick();

    // Single op on CP1, issue held while cop_ready is low
    bus.req_valid = 1'b1;
    bus.req_inst  = 32'h4480_0000;
    bus.req_data  = 32'h1234_5678;
    #1;
    chk("t1_req_ready_idle", bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    #1;
    chk("t1_cop_valid", bus.cop_valid, 2'b10);
    chk("t1_cop_inst", bus.cop_inst, 32'h4480_0000);
    chk("t1_cop_data", bus.cop_data, 32'h1234_5678);
    chk("t1_outstanding", bus.outstanding, 3'd1);
    chk("t1_req_ready_blocked", bus.req_ready, 1'b0);
    chk("t1_rsp_valid_wait", bus.rsp_valid, 1'b0);
    bus.cop_ready = 2'b10;
    #1;
    chk("t1_req_ready_fire", bus.req_ready, 1'b1);
    tick();
    bus.cop_ready = 2'b00;
    #1;
    chk("t1_cop_valid_done", bus.cop_valid, 2'b00);
    bus.cop_rsp_valid = 2'b10;
    bus.cop_rsp_data  = {32'hCAFE_F00D, 32'h0};
    bus.rsp_ready     = 1'b1;
    #1;
    chk("t1_rsp_valid", bus.rsp_valid, 1'b1);
    chk("t1_rsp_data", bus.rsp_data, 32'hCAFE_F00D);
    chk("t1_rsp_err", bus.rsp_err, 1'b0);
    chk("t1_cop_rsp_ready", bus.cop_rsp_ready, 2'b10);
    tick();
    bus.cop_rsp_valid = 2'b00;
    bus.rsp_ready     = 1'b0;
    #1;
    chk("t1_outstanding_end", bus.outstanding, 3'd0);

    // Out-of-order completion: CP1 answers before CP0
    bus.cop_ready = 2'b11;
    push(32'h4000_0000, 32'h1);
    #1;
    chk("t2_cop_valid_cp0", bus.cop_valid, 2'b01);
    push(32'h4400_0000, 32'h2);
    #1;
    chk("t2_cop_valid_cp1", bus.cop_valid, 2'b10);
    chk("t2_outstanding", bus.outstanding, 3'd2);
    tick();
    bus.cop_rsp_valid = 2'b10;
    bus.cop_rsp_data  = {32'hBBBB_0001, 32'h0};
    bus.rsp_ready     = 1'b1;
    #1;
    chk("t2_cp1_held", bus.cop_rsp_ready, 2'b01);
    chk("t2_rsp_valid_wait", bus.rsp_valid, 1'b0);
    tick();
    #1;
    chk("t2_no_pop", bus.outstanding, 3'd2);
    bus.cop_rsp_valid = 2'b11;
    bus.cop_rsp_data  = {32'hBBBB_0001, 32'hAAAA_0000};
    #1;
    chk("t2_first_valid", bus.rsp_valid, 1'b1);
    chk("t2_first_data", bus.rsp_data, 32'hAAAA_0000);
    tick();
    bus.cop_rsp_valid = 2'b10;
    #1;
    chk("t2_second_valid", bus.rsp_valid, 1'b1);
    chk("t2_second_data", bus.rsp_data, 32'hBBBB_0001);
    chk("t2_second_ready", bus.cop_rsp_ready, 2'b10);
    tick();
    bus.cop_rsp_valid = 2'b00;
    bus.rsp_ready     = 1'b0;
    #1;
    chk("t2_outstanding_end", bus.outstanding, 3'd0);

    // Illegal instruction between two CP0 ops
    bus.cop_ready = 2'b01;
    push(32'h4000_0001, 32'h3);
    push(32'h0000_0020, 32'h0);
    #1;
    chk("t3_illegal_no_dispatch", bus.cop_valid, 2'b00);
    push(32'h4000_0002, 32'h4);
    #1;
    chk("t3_cop_valid", bus.cop_valid, 2'b01);
    chk("t3_cop_inst", bus.cop_inst, 32'h4000_0002);
    chk("t3_outstanding", bus.outstanding, 3'd3);
    tick();
    bus.cop_rsp_valid = 2'b01;
    bus.cop_rsp_data  = {32'h0, 32'h0000_0111};
    bus.rsp_ready     = 1'b1;
    #1;
    chk("t3_rsp1_data", bus.rsp_data, 32'h0000_0111);
    chk("t3_rsp1_err", bus.rsp_err, 1'b0);
    tick();
    bus.cop_rsp_data = {32'h0, 32'h0000_0222};
    #1;
    chk("t3_err_valid", bus.rsp_valid, 1'b1);
    chk("t3_err_flag", bus.rsp_err, 1'b1);
    chk("t3_err_data", bus.rsp_data, 32'h0);
    chk("t3_err_cop_rsp_ready", bus.cop_rsp_ready, 2'b00);
    tick();
    #1;
    chk("t3_rsp3_data", bus.rsp_data, 32'h0000_0222);
    chk("t3_rsp3_err", bus.rsp_err, 1'b0);
    tick();
    bus.cop_rsp_valid = 2'b00;
    bus.rsp_ready     = 1'b0;
    #1;
    chk("t3_outstanding_end", bus.outstanding, 3'd0);

    // Unpopulated coprocessor (COP3 with two channels)
    push(32'h4C00_0000, 32'h5);
    #1;
    chk("t3b_no_dispatch", bus.cop_valid, 2'b00);
    chk("t3b_err_valid", bus.rsp_valid, 1'b1);
    chk("t3b_err_flag", bus.rsp_err, 1'b1);
    chk("t3b_outstanding", bus.outstanding, 3'd1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    chk("t3b_outstanding_end", bus.outstanding, 3'd0);

    // FIFO full and back-pressure, with back-to-back issue
    bus.cop_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      push(32'h4000_0010 + 32'(i), 32'(i));
      #1;
      chk("t4_b2b_cop_valid", bus.cop_valid, 2'b01);
    end
    chk("t4_full_outstanding", bus.outstanding, 3'd4);
    chk("t4_full_req_ready", bus.req_ready, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_inst  = 32'h4000_0020;
    tick();
    #1;
    chk("t4_refused", bus.outstanding, 3'd4);
    bus.cop_rsp_valid = 2'b01;
    bus.rsp_ready     = 1'b1;
    #1;
    chk("t4_pop_not_freeing", bus.req_ready, 1'b0);
    tick();
    bus.req_valid = 1'b0;
    #1;
    chk("t4_after_pop_outstanding", bus.outstanding, 3'd3);
    chk("t4_after_pop_req_ready", bus.req_ready, 1'b1);
    tick(); tick(); tick();
    bus.cop_rsp_valid = 2'b00;
    bus.rsp_ready     = 1'b0;
    #1;
    chk("t4_drained", bus.outstanding, 3'd0);

    // Sticky flags on CP0
    bus.cop_ready = 2'b01;
    push(32'h4000_0030, 32'h0);
    push(32'h4000_0031, 32'h0);
    push(32'h4000_0032, 32'h0);
    tick();
    bus.cop_rsp_valid = 2'b01;
    bus.rsp_ready     = 1'b1;
    bus.cop_rsp_flags = 16'h0001;
    tick();
    bus.cop_rsp_flags = 16'h0004;
    tick();
    bus.rsp_ready     = 1'b0;
    #1;
`ifdef COP_DISPATCH_STICKY_FLAGS_EN
    exp_sticky = 16'h0005;
`else
    exp_sticky = 16'h0000;
`endif
    chk("t5_sticky_accum", bus.sticky_flags, exp_sticky);
    bus.flags_clr     = 1'b1;
    bus.cop_rsp_flags = 16'h0002;
    bus.rsp_ready     = 1'b1;
    tick();
    bus.flags_clr     = 1'b0;
    bus.rsp_ready     = 1'b0;
    bus.cop_rsp_valid = 2'b00;
    bus.cop_rsp_flags = 16'h0000;
    #1;
`ifdef COP_DISPATCH_STICKY_FLAGS_EN
    exp_sticky = 16'h0002;
`else
    exp_sticky = 16'h0000;
`endif
    chk("t5_sticky_clr_set", bus.sticky_flags, exp_sticky);
    chk("t5_outstanding", bus.outstanding, 3'd0);

    // Asynchronous reset in the middle of a held issue
    bus.cop_ready = 2'b00;
    push(32'h4400_0003, 32'h0000_DEAD);
    #1;
    chk("t6_pre_cop_valid", bus.cop_valid, 2'b10);
    chk("t6_pre_outstanding", bus.outstanding, 3'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_cop_valid", bus.cop_valid, 2'b00);
    chk("t6_outstanding", bus.outstanding, 3'd0);
    chk("t6_sticky", bus.sticky_flags, 16'h0);
    chk("t6_req_ready", bus.req_ready, 1'b1);
    chk("t6_cop_inst", bus.cop_inst, 32'h0);
    chk("t6_cop_data", bus.cop_data, 32'h0);
    chk("t6_rsp_valid", bus.rsp_valid, 1'b0);
    chk("t6_rsp_err", bus.rsp_err, 1'b0);
    chk("t6_rsp_data", bus.rsp_data, 32'h0);
    chk("t6_cop_rsp_ready", bus.cop_rsp_ready, 2'b00);
    tick();
    rst = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
